// File: rtl/mul_booth_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier.
//   state_t      : FSM state encoding (idle / calculate / done)
//   booth_cmd_t  : decoded Booth digit, {neg, mag[1:0]} with mag in {0,1,2}
//   booth_digits : number of radix-4 digits for an operand width
//   booth_decode : Booth digit table for a 3-bit multiplier window
package mul_booth_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } state_t;

   localparam logic [1:0] MagZero = 2'd0;
   localparam logic [1:0] MagOne  = 2'd1;
   localparam logic [1:0] MagTwo  = 2'd2;

   typedef struct packed {
      logic       neg;
      logic [1:0] mag;
   } booth_cmd_t;

   // One extra digit covers the two extension bits of the operands.
   function automatic int unsigned booth_digits(input int unsigned n);
      return n / 2 + 1;
   endfunction

   function automatic booth_cmd_t booth_decode(input logic [2:0] bits);
      booth_cmd_t cmd;
      cmd.neg = 1'b0;
      cmd.mag = MagZero;
      case (bits)
         3'b001, 3'b010: cmd.mag = MagOne;
         3'b011:         cmd.mag = MagTwo;
         3'b100: begin
            cmd.neg = 1'b1;
            cmd.mag = MagTwo;
         end
         3'b101, 3'b110: begin
            cmd.neg = 1'b1;
            cmd.mag = MagOne;
         end
         default: begin
            cmd.neg = 1'b0;
            cmd.mag = MagZero;
         end
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/mul_booth_seq_if.sv
// Request/response bundle of the sequential Booth multiplier.
//   master : requester side (drives iSTART/iSIGNED/iDATA_0/iDATA_1/iFLUSH)
//   slave  : multiplier side (drives oREADY/oBUSY/oVALID/oDATA/oSF/oZF/oOF)
interface mul_booth_seq_if #(
   parameter int unsigned P_N = 32
);
   logic               iSTART;
   logic               iSIGNED;
   logic [P_N-1:0]     iDATA_0;
   logic [P_N-1:0]     iDATA_1;
   logic               iFLUSH;
   logic               oREADY;
   logic               oBUSY;
   logic               oVALID;
   logic [2*P_N-1:0]   oDATA;
   logic               oSF;
   logic               oZF;
   logic               oOF;

   modport master (
      output iSTART, iSIGNED, iDATA_0, iDATA_1, iFLUSH,
      input  oREADY, oBUSY, oVALID, oDATA, oSF, oZF, oOF
   );

   modport slave (
      input  iSTART, iSIGNED, iDATA_0, iDATA_1, iFLUSH,
      output oREADY, oBUSY, oVALID, oDATA, oSF, oZF, oOF
   );
endinterface

// File: rtl/mul_booth_pp.sv
// Radix-4 Booth partial-product generator (combinational).
//   mcand : multiplicand already extended to P_N+2 bits
//   bits  : multiplier window {b[2k+1], b[2k], b[2k-1]}
//   pp    : partial product 0, +-M or +-2M, sign-extended to P_N+3 bits
module mul_booth_pp
   import mul_booth_pkg::*;
#(
   parameter int unsigned P_N = 32
) (
   input  logic [P_N+1:0] mcand,
   input  logic [2:0]     bits,
   output logic [P_N+2:0] pp
);

   booth_cmd_t     cmd;
   logic [P_N+2:0] mag;

   always_comb begin
      cmd = booth_decode(bits);
      mag = '0;
      unique case (cmd.mag)
         MagOne:  mag = {mcand[P_N+1], mcand};
         MagTwo:  mag = {mcand, 1'b0};
         default: mag = '0;
      endcase
      // Extended operands never reach -2^(P_N+1), so -2M cannot overflow here.
      pp = cmd.neg ? -mag : mag;
   end

endmodule

// File: rtl/mul_booth_seq.sv
// Sequential radix-4 Booth multiplier, one partial product per clock.
//   iCLOCK  : clock
//   inRESET : asynchronous active-low reset
//   bus     : request (start/signed/operands/flush) and response
//             (ready/busy/valid pulse, 2*P_N-bit product, SF/ZF/OF flags)
// Accept at edge t, CALC for P_D edges, result and flags registered on the
// edge that leaves DONE, so oVALID appears P_D+1 cycles after accept.
module mul_booth_seq
   import mul_booth_pkg::*;
#(
   parameter int unsigned P_N = 32
) (
   input logic            iCLOCK,
   input logic            inRESET,
   mul_booth_seq_if.slave bus
);

   localparam int unsigned P_D = booth_digits(P_N);
   localparam int unsigned CW  = $clog2(P_D);
   localparam int unsigned AW  = 2 * P_N + 2;
   localparam logic [CW-1:0] CntLast = CW'(P_D - 1);

   if (P_N < 4 || (P_N % 2) != 0) begin : g_bad_param
      $error("mul_booth_seq: P_N must be even and >= 4");
   end

   state_t            state_q, state_d;
   logic              ready, busy, accept;

   logic [P_N+1:0]    mcand_q, mcand_ext;
   logic [P_N+2:0]    mplier_q;  // multiplier with an implicit 0 below its LSB
   logic [P_N+1:0]    mplier_ext;
   logic [AW-1:0]     acc_q;
   logic [CW-1:0]     cnt_q;
   logic              signed_q;

   logic [P_N+2:0]    pp;
   logic [AW-1:0]     pp_wide, pp_shift;

   logic [2*P_N-1:0]  res;
   logic              res_of;

   logic              valid_q, sf_q, zf_q, of_q;
   logic [2*P_N-1:0]  data_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) state_q <= StIdle;
      else          state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StCalc;
         StCalc: begin
            if (bus.iFLUSH)             state_d = StIdle;
            else if (cnt_q == CntLast)  state_d = StDone;
         end
         StDone:  state_d = accept ? StCalc : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ready  = (state_q == StIdle) || (state_q == StDone);
      busy   = (state_q == StCalc);
      // Flush wins over a same-cycle start.
      accept = bus.iSTART && ready && !bus.iFLUSH;
   end

   // ---------------- datapath ----------------
   always_comb begin
      mcand_ext  = bus.iSIGNED ? {{2{bus.iDATA_0[P_N-1]}}, bus.iDATA_0}
                               : {2'b00, bus.iDATA_0};
      mplier_ext = bus.iSIGNED ? {{2{bus.iDATA_1[P_N-1]}}, bus.iDATA_1}
                               : {2'b00, bus.iDATA_1};
      pp_wide    = {{(P_N-1){pp[P_N+2]}}, pp};
      pp_shift   = pp_wide << {cnt_q, 1'b0};
   end

   mul_booth_pp #(
      .P_N (P_N)
   ) u_pp (
      .mcand (mcand_q),
      .bits  (mplier_q[2:0]),
      .pp    (pp)
   );

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         signed_q <= 1'b0;
      end else if (accept) begin
         mcand_q  <= mcand_ext;
         mplier_q <= {mplier_ext, 1'b0};
         acc_q    <= '0;
         cnt_q    <= '0;
         signed_q <= bus.iSIGNED;
      end else if (state_q == StCalc) begin
         acc_q    <= acc_q + pp_shift;
         cnt_q    <= cnt_q + 1'b1;
         // Shifting keeps the current digit window in the low three bits.
         mplier_q <= mplier_q >> 2;
      end
   end

   // ---------------- result and flags ----------------
   always_comb begin
      res    = acc_q[2*P_N-1:0];
      res_of = signed_q ? (res[2*P_N-1:P_N] != {P_N{res[P_N-1]}})
                        : (res[2*P_N-1:P_N] != '0);
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sf_q    <= 1'b0;
         zf_q    <= 1'b1;
         of_q    <= 1'b0;
      end else begin
         valid_q <= (state_q == StDone);
         if (state_q == StDone) begin
            data_q <= res;
            sf_q   <= res[2*P_N-1];
            zf_q   <= (res == '0);
            of_q   <= res_of;
         end
      end
   end

   assign bus.oREADY = ready;
   assign bus.oBUSY  = busy;
   assign bus.oVALID = valid_q;
   assign bus.oDATA  = data_q;
   assign bus.oSF    = sf_q;
   assign bus.oZF    = zf_q;
   assign bus.oOF    = of_q;

endmodule

// File: tb/tb_mul_booth_seq.sv
// Self-checking bench: a 32-bit and a 4-bit multiplier instance driven with
// directed and random requests, compared against an arithmetic reference.
module tb_mul_booth_seq;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_errors = 0;

   mul_booth_seq_if #(.P_N(32)) bus32 ();
   mul_booth_seq_if #(.P_N(4))  bus4 ();

   mul_booth_seq #(.P_N(32)) u_dut32 (
      .iCLOCK  (clk),
      .inRESET (rst_n),
      .bus     (bus32)
   );

   mul_booth_seq #(.P_N(4)) u_dut4 (
      .iCLOCK  (clk),
      .inRESET (rst_n),
      .bus     (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Exact product from plain integer arithmetic, truncated to 2n bits.
   function automatic void ref_model(input int unsigned n, input logic [31:0] a,
                                     input logic [31:0] b, input logic sgn,
                                     output logic [63:0] p, output logic sf,
                                     output logic zf, output logic of);
      logic [63:0] mask, av, bv, prod, pmask;
      longint      sp, lo, hi;
      mask = (64'd1 << n) - 64'd1;
      av   = 64'(a) & mask;
      bv   = 64'(b) & mask;
      if (sgn && a[n-1]) av = av | ~mask;
      if (sgn && b[n-1]) bv = bv | ~mask;
      prod  = av * bv;
      pmask = (n == 32) ? '1 : ((64'd1 << (2 * n)) - 64'd1);
      p     = prod & pmask;
      sf    = p[2*n-1];
      zf    = (p == 64'd0);
      if (sgn) begin
         sp = $signed(prod);
         lo = -(longint'(1) << (n - 1));
         hi = (longint'(1) << (n - 1)) - 1;
         of = (sp < lo) || (sp > hi);
      end else begin
         of = (prod >= (64'd1 << n));
      end
   endfunction

   function automatic logic [63:0] obs_data(input bit w4);
      return w4 ? 64'(bus4.oDATA) : bus32.oDATA;
   endfunction

   function automatic logic [63:0] obs_flags(input bit w4);
      return w4 ? 64'({bus4.oSF, bus4.oZF, bus4.oOF}) : 64'({bus32.oSF, bus32.oZF, bus32.oOF});
   endfunction

   function automatic logic obs_valid(input bit w4);
      return w4 ? bus4.oVALID : bus32.oVALID;
   endfunction

   // Waits until oVALID, counting edges after the accept edge (bounded).
   task automatic wait_valid(input bit w4, output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!obs_valid(w4) && lat < 64);
   endtask

   // One complete request from an idle multiplier; returns the expected product.
   task automatic run_op(input bit w4, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input string tag, output logic [63:0] ep);
      logic        esf, ezf, eof;
      int          lat;
      int unsigned n;
      n = w4 ? 4 : 32;
      ref_model(n, a, b, sgn, ep, esf, ezf, eof);
      @(negedge clk);
      if (w4) begin
         bus4.iDATA_0 = a[3:0];
         bus4.iDATA_1 = b[3:0];
         bus4.iSIGNED = sgn;
         bus4.iSTART  = 1'b1;
      end else begin
         bus32.iDATA_0 = a;
         bus32.iDATA_1 = b;
         bus32.iSIGNED = sgn;
         bus32.iSTART  = 1'b1;
      end
      @(posedge clk);
      #1;
      bus4.iSTART  = 1'b0;
      bus32.iSTART = 1'b0;
      wait_valid(w4, lat);
      check({tag, " latency"}, 64'(lat), 64'(n / 2 + 2));
      check({tag, " data"}, obs_data(w4), ep);
      check({tag, " flags{sf,zf,of}"}, obs_flags(w4), 64'({esf, ezf, eof}));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " ctrl{valid,busy,ready,sf,zf,of}"},
            64'({bus32.oVALID, bus32.oBUSY, bus32.oREADY, bus32.oSF, bus32.oZF, bus32.oOF}),
            64'(6'b001010));
      check({tag, " data"}, bus32.oDATA, 64'd0);
   endtask

   initial begin
      logic [63:0] ep, last;
      logic [31:0] a, b;
      logic        sgn;
      int          lat;
      bit          saw;

      rst_n = 1'b0;
      bus32.iSTART = 1'b0; bus32.iSIGNED = 1'b0; bus32.iFLUSH = 1'b0;
      bus32.iDATA_0 = '0;  bus32.iDATA_1 = '0;
      bus4.iSTART = 1'b0;  bus4.iSIGNED = 1'b0;  bus4.iFLUSH = 1'b0;
      bus4.iDATA_0 = '0;   bus4.iDATA_1 = '0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      check("reset p4 ctrl", 64'({bus4.oVALID, bus4.oBUSY, bus4.oREADY, bus4.oZF}),
            64'(4'b0011));
      @(negedge clk);
      rst_n = 1'b1;

      // Directed signed/unsigned corner products.
      run_op(1'b0, 32'hFFFFFFFD, 32'd7, 1'b1, "neg3x7", ep);
      check("neg3x7 const", bus32.oDATA, 64'hFFFFFFFF_FFFFFFEB);
      run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "umax", ep);
      check("umax const", bus32.oDATA, 64'hFFFFFFFE_00000001);
      check("umax of", 64'(bus32.oOF), 64'd1);
      run_op(1'b0, 32'h80000000, 32'h80000000, 1'b1, "smin", ep);
      check("smin const", bus32.oDATA, 64'h40000000_00000000);
      check("smin of", 64'(bus32.oOF), 64'd1);
      run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, "umin", ep);
      check("umin const", bus32.oDATA, 64'h40000000_00000000);

      // iSTART held through CALC: ignored until DONE, then back-to-back accept.
      @(negedge clk);
      bus32.iDATA_0 = 32'd0; bus32.iDATA_1 = 32'h12345678;
      bus32.iSIGNED = 1'b0;  bus32.iSTART  = 1'b1;
      @(posedge clk);
      #1;
      bus32.iDATA_0 = 32'd3; bus32.iDATA_1 = 32'd5; bus32.iSIGNED = 1'b1;
      check("held busy", 64'(bus32.oBUSY), 64'd1);
      wait_valid(1'b0, lat);
      check("zero latency", 64'(lat), 64'd18);
      check("zero data", bus32.oDATA, 64'd0);
      check("zero zf", 64'(bus32.oZF), 64'd1);
      check("b2b accepted", 64'(bus32.oBUSY), 64'd1);
      bus32.iSTART = 1'b0;
      wait_valid(1'b0, lat);
      check("b2b latency", 64'(lat), 64'd18);
      check("b2b data", bus32.oDATA, 64'd15);
      last = 64'd15;

      // Flush during CALC: no result, old product held.
      @(negedge clk);
      bus32.iDATA_0 = 32'd5; bus32.iDATA_1 = 32'd6; bus32.iSIGNED = 1'b0;
      bus32.iSTART  = 1'b1;
      @(posedge clk);
      #1;
      bus32.iSTART = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      bus32.iFLUSH = 1'b1;
      @(posedge clk);
      #1;
      bus32.iFLUSH = 1'b0;
      check("flush ready", 64'({bus32.oBUSY, bus32.oREADY}), 64'(2'b01));
      saw = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (bus32.oVALID) saw = 1'b1;
      end
      check("flush no valid", 64'(saw), 64'd0);
      check("flush data held", bus32.oDATA, last);

      // Flush with a same-cycle start in IDLE cancels the start.
      @(negedge clk);
      bus32.iSTART = 1'b1; bus32.iFLUSH = 1'b1;
      @(posedge clk);
      #1;
      bus32.iSTART = 1'b0; bus32.iFLUSH = 1'b0;
      check("flush cancels start", 64'(bus32.oBUSY), 64'd0);

      run_op(1'b0, 32'd5, 32'd6, 1'b0, "retry", ep);
      check("retry const", bus32.oDATA, 64'd30);

      // Reset in the middle of CALC.
      @(negedge clk);
      bus32.iDATA_0 = 32'd7; bus32.iDATA_1 = 32'd9; bus32.iSTART = 1'b1;
      @(posedge clk);
      #1;
      bus32.iSTART = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, 32'd7, 32'd9, 1'b1, "post reset", ep);

      // Random operands, both modes, with some extreme values mixed in.
      for (int i = 0; i < 2000; i++) begin
         a   = $urandom;
         b   = $urandom;
         sgn = 1'($urandom_range(0, 1));
         if (i % 16 == 0) a = 32'h80000000;
         if (i % 16 == 1) b = 32'hFFFFFFFF;
         if (i % 16 == 2) a = 32'h7FFFFFFF;
         run_op(1'b0, a, b, sgn, "rnd32", ep);
      end

      // Exhaustive 4-bit instance.
      for (int s = 0; s < 2; s++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               run_op(1'b1, 32'(x), 32'(y), 1'(s), "exh4", ep);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
